// File: rtl/dds_pkg.sv
// Shared definitions for the DDS generator: waveform mode encodings and the
// default parameter values used by dds_gen and dds_sine_rom.
package dds_pkg;

  typedef enum logic [1:0] {
    ModeSquare = 2'd0,
    ModeSaw    = 2'd1,
    ModeTri    = 2'd2,
    ModeSine   = 2'd3
  } dds_mode_e;

  localparam int unsigned PhaseWDefault = 32;
  localparam int unsigned PoffWDefault  = 12;
  localparam int unsigned OutWDefault   = 10;
  localparam int unsigned LutAwDefault  = 8;

endpackage

// File: rtl/dds_sine_rom.sv
// Quarter-wave sine magnitude ROM (combinational).
// Ports:
//   addr : quarter-wave index, LUT_AW bits
//   mag  : round((2^(OUT_W-1)-1) * sin((addr+0.5)*pi/2^(LUT_AW+1))), OUT_W-1 bits
// Table contents are computed at elaboration; the half-step offset keeps the
// quarter symmetric so mirroring by bitwise inverse is exact.
module dds_sine_rom import dds_pkg::*; #(
  parameter int unsigned LUT_AW = LutAwDefault,
  parameter int unsigned OUT_W  = OutWDefault
) (
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  mag
);

  localparam int unsigned Depth = 1 << LUT_AW;
  localparam real Pi = 3.14159265358979323846;

  function automatic logic [OUT_W-2:0] sine_mag(input int idx);
    real amp;
    real ang;
    amp = real'((1 << (OUT_W - 1)) - 1);
    ang = (real'(idx) + 0.5) * Pi / real'(1 << (LUT_AW + 1));
    return (OUT_W - 1)'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-2:0] rom [Depth];

  for (genvar i = 0; i < Depth; i++) begin : g_rom
    assign rom[i] = sine_mag(i);
  end

  assign mag = rom[addr];

endmodule

// File: rtl/dds_gen.sv
// Direct digital synthesis waveform generator.
// Ports:
//   clk, rst_n         : clock (rising edge), async active-low reset
//   en                 : advance phase accumulator
//   clr                : synchronous accumulator clear (wins over en)
//   cfg_valid/ready    : config handshake for cfg_k (tuning word), cfg_p
//                        (phase offset), cfg_mode (0 square,1 saw,2 tri,3 sine)
//   wave_out/valid     : offset-binary sample and its qualifier (en delayed 2)
//   sync_out           : marks the sample taken at the start of a period
// Pipeline: acc -> ph (acc top bits + offset) -> wave_out.
module dds_gen import dds_pkg::*; #(
  parameter int unsigned PHASE_W = PhaseWDefault,
  parameter int unsigned POFF_W  = PoffWDefault,
  parameter int unsigned OUT_W   = OutWDefault,
  parameter int unsigned LUT_AW  = LutAwDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_k,
  input  logic [POFF_W-1:0]  cfg_p,
  input  logic [1:0]         cfg_mode,
  output logic [OUT_W-1:0]   wave_out,
  output logic               wave_valid,
  output logic               sync_out
);

  // Lowest phase bit any waveform looks at; bits below it are never stored.
  localparam int unsigned PhLsb = ((POFF_W - 1 - OUT_W) < (POFF_W - 2 - LUT_AW)) ?
                                  (POFF_W - 1 - OUT_W) : (POFF_W - 2 - LUT_AW);
  localparam int unsigned PhW   = POFF_W - PhLsb;
  localparam logic [OUT_W-1:0] Mid   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MidM1 = {1'b0, {(OUT_W-1){1'b1}}};

  logic [PHASE_W-1:0]  acc_q, acc_d, k_act_q, k_pend_q;
  logic [PHASE_W:0]    acc_sum;
  logic [POFF_W-1:0]   p_act_q, p_pend_q;
  dds_mode_e           mode_act_q, mode_pend_q, ph_mode_q;
  logic                pend_q, start_q, carry, apply, accept;
  logic [POFF_W-1:PhLsb] ph_q, ph_d;
  logic                ph_valid_q, ph_sync_q;
  logic [OUT_W-1:0]    wave_q, wave_d, tri_val;
  logic                valid_q, sync_q;
  logic [1:0]          quad;
  logic [LUT_AW-1:0]   lut_idx, lut_addr;
  logic [OUT_W-2:0]    lut_mag;

  assign acc_sum = {1'b0, acc_q} + {1'b0, k_act_q};
  assign carry   = en & ~clr & acc_sum[PHASE_W];
  // Pending config lands only on a period boundary, or immediately when idle.
  assign apply   = pend_q & (carry | ~en);
  assign accept  = cfg_valid & ~pend_q;
  assign cfg_ready = ~pend_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_sum[PHASE_W-1:0];
    end
  end

  assign ph_d = PhW'((acc_q[PHASE_W-1 -: POFF_W] + p_act_q) >> PhLsb);

  assign quad     = ph_q[POFF_W-1 -: 2];
  assign lut_idx  = ph_q[POFF_W-3 -: LUT_AW];
  assign lut_addr = quad[0] ? ~lut_idx : lut_idx;
  assign tri_val  = ph_q[POFF_W-2 -: OUT_W];

  dds_sine_rom #(
    .LUT_AW(LUT_AW),
    .OUT_W (OUT_W)
  ) u_sine_rom (
    .addr(lut_addr),
    .mag (lut_mag)
  );

  always_comb begin
    wave_d = '0;
    unique case (ph_mode_q)
      ModeSquare: wave_d = quad[1] ? '0 : '1;
      ModeSaw:    wave_d = ph_q[POFF_W-1 -: OUT_W];
      ModeTri:    wave_d = quad[1] ? ~tri_val : tri_val;
      ModeSine:   wave_d = quad[1] ? (MidM1 - {1'b0, lut_mag}) : (Mid + {1'b0, lut_mag});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      // acc=0 out of reset is treated as a period start; clr is not.
      start_q     <= 1'b1;
      k_act_q     <= '0;
      p_act_q     <= '0;
      mode_act_q  <= ModeSquare;
      k_pend_q    <= '0;
      p_pend_q    <= '0;
      mode_pend_q <= ModeSquare;
      pend_q      <= 1'b0;
      ph_q        <= '0;
      ph_mode_q   <= ModeSquare;
      ph_sync_q   <= 1'b0;
      ph_valid_q  <= 1'b0;
      wave_q      <= '0;
      valid_q     <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (clr || en) begin
        start_q <= carry;
      end
      if (accept) begin
        pend_q      <= 1'b1;
        k_pend_q    <= cfg_k;
        p_pend_q    <= cfg_p;
        mode_pend_q <= dds_mode_e'(cfg_mode);
      end else if (apply) begin
        pend_q     <= 1'b0;
        k_act_q    <= k_pend_q;
        p_act_q    <= p_pend_q;
        mode_act_q <= mode_pend_q;
      end
      ph_valid_q <= en;
      if (en) begin
        ph_q      <= ph_d;
        ph_mode_q <= mode_act_q;
        ph_sync_q <= start_q;
      end
      valid_q <= ph_valid_q;
      sync_q  <= ph_valid_q & ph_sync_q;
      if (ph_valid_q) begin
        wave_q <= wave_d;
      end
    end
  end

  assign wave_out   = wave_q;
  assign wave_valid = valid_q;
  assign sync_out   = sync_q;

endmodule
